// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register-file write port through a one-entry stage.
// Optional combinational write-through forwarding of the staged write is enabled with `define REGWB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wbStall,
    output logic                    writeRegMem,
    output logic [4:0]              rd,
    output logic [XLEN-1:0]         dataIn
`ifdef REGWB_FWD_EN
    ,
    input  logic [4:0]              fwd_addr1,
    input  logic [4:0]              fwd_addr2,
    input  logic [XLEN-1:0]         fwd_rs1_in,
    input  logic [XLEN-1:0]         fwd_rs2_in,
    output logic [XLEN-1:0]         fwd_rs1,
    output logic [XLEN-1:0]         fwd_rs2
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                stage_valid_reg, stage_valid_next;
    logic [4:0]          stage_rd_reg, stage_rd_next;
    logic [XLEN-1:0]     stage_data_reg, stage_data_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;

    logic                drain;
    logic                can_accept;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_any;
    logic [PTR_W:0]      scan_idx;
    logic [PTR_W-1:0]    scan_ptr;

    logic [4:0]          rd_slice   [NUM_REQ];
    logic [XLEN-1:0]     data_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign rd_slice[gi]   = req_rd[5*gi +: 5];
            assign data_slice[gi] = req_data[XLEN*gi +: XLEN];
        end
    endgenerate

    assign drain      = stage_valid_reg & ~wbStall;
    assign can_accept = ~wbStall & (~stage_valid_reg | drain);

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        scan_ptr  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            end
            scan_ptr = scan_idx[PTR_W-1:0];
            if (!grant_any && req_valid[scan_ptr]) begin
                grant_any       = 1'b1;
                grant_idx       = scan_ptr;
                grant[scan_ptr] = 1'b1;
            end
        end
        if (!can_accept) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    // Grants are suppressed while reset is asserted so no requester sees a handshake.
    assign req_ready = grant & {NUM_REQ{nReset}};

    always_comb begin
        stage_valid_next = stage_valid_reg;
        stage_rd_next    = stage_rd_reg;
        stage_data_next  = stage_data_reg;
        rr_ptr_next      = rr_ptr_reg;
        if (grant_any) begin
            stage_valid_next = 1'b1;
            stage_rd_next    = rd_slice[grant_idx];
            stage_data_next  = data_slice[grant_idx];
            if (grant_idx == PTR_W'(NUM_REQ-1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + PTR_W'(1);
            end
        end else if (drain) begin
            stage_valid_next = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stage_valid_reg <= 1'b0;
            stage_rd_reg    <= '0;
            stage_data_reg  <= '0;
            rr_ptr_reg      <= '0;
        end else begin
            stage_valid_reg <= stage_valid_next;
            stage_rd_reg    <= stage_rd_next;
            stage_data_reg  <= stage_data_next;
            rr_ptr_reg      <= rr_ptr_next;
        end
    end

    // x0 entries occupy the stage but never reach the register file.
    assign writeRegMem = stage_valid_reg & ~wbStall & (stage_rd_reg != 5'd0);
    assign rd          = stage_rd_reg;
    assign dataIn      = stage_data_reg;

`ifdef REGWB_FWD_EN
    assign fwd_rs1 = (writeRegMem && (stage_rd_reg == fwd_addr1)) ? stage_data_reg : fwd_rs1_in;
    assign fwd_rs2 = (writeRegMem && (stage_rd_reg == fwd_addr2)) ? stage_data_reg : fwd_rs2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a queue-free behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N    = 3;
    localparam int XLEN = 32;

    logic              Clock;
    logic              nReset;
    logic [N-1:0]      req_valid;
    logic [N*5-1:0]    req_rd;
    logic [N*XLEN-1:0] req_data;
    logic [N-1:0]      req_ready;
    logic              wbStall;
    logic              writeRegMem;
    logic [4:0]        rd;
    logic [XLEN-1:0]   dataIn;
`ifdef REGWB_FWD_EN
    logic [4:0]        fwd_addr1, fwd_addr2;
    logic [XLEN-1:0]   fwd_rs1_in, fwd_rs2_in, fwd_rs1, fwd_rs2;
`endif

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wbStall     (wbStall),
        .writeRegMem (writeRegMem),
        .rd          (rd),
        .dataIn      (dataIn)
`ifdef REGWB_FWD_EN
        ,
        .fwd_addr1   (fwd_addr1),
        .fwd_addr2   (fwd_addr2),
        .fwd_rs1_in  (fwd_rs1_in),
        .fwd_rs2_in  (fwd_rs2_in),
        .fwd_rs1     (fwd_rs1),
        .fwd_rs2     (fwd_rs2)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model: one optional pending write plus the next-search start index.
    bit          m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_ptr;
    int          last_g;
    int          mode;
    int          wr_dut;
    logic [31:0] rf_model [32];
    logic [31:0] rf_dut   [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        req_valid[i]         = v;
        req_rd[5*i +: 5]     = r;
        req_data[32*i +: 32] = d;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_rd    = '0;
        m_data  = '0;
        m_ptr   = 0;
    endtask

    function automatic int model_grant();
        if (!nReset || wbStall) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_cycle(input string tag);
        logic [63:0] exp_ready;
        logic        exp_wr;
        @(negedge Clock);
        last_g    = model_grant();
        exp_ready = (last_g >= 0) ? (64'd1 << last_g) : 64'd0;
        exp_wr    = m_valid && !wbStall && (m_rd != 5'd0);
        chk({tag, ".ready"}, 64'(req_ready), exp_ready);
        chk({tag, ".wr"},    64'(writeRegMem), 64'(exp_wr));
        chk({tag, ".rd"},    64'(rd), 64'(m_rd));
        chk({tag, ".data"},  64'(dataIn), 64'(m_data));
`ifdef REGWB_FWD_EN
        chk({tag, ".fwd1"}, 64'(fwd_rs1), 64'((exp_wr && m_rd == fwd_addr1) ? m_data : fwd_rs1_in));
        chk({tag, ".fwd2"}, 64'(fwd_rs2), 64'((exp_wr && m_rd == fwd_addr2) ? m_data : fwd_rs2_in));
`endif
        if (writeRegMem) begin
            rf_dut[rd] = dataIn;
            wr_dut++;
        end
        if (exp_wr) rf_model[m_rd] = m_data;
    endtask

    task automatic adv();
        if (!wbStall) begin
            if (last_g >= 0) begin
                m_valid = 1;
                m_rd    = req_rd[5*last_g +: 5];
                m_data  = req_data[32*last_g +: 32];
                m_ptr   = (last_g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge Clock);
        #1;
        if (mode >= 1 && last_g >= 0) begin
            req_valid[last_g] = 1'b0;
            if (mode == 2 && $urandom_range(1) == 1)
                set_req(last_g, 1'b1, 5'($urandom_range(7)), $urandom());
        end
        if (mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0)
                    set_req(i, 1'b1, 5'($urandom_range(7)), $urandom());
            end
            wbStall = ($urandom_range(4) == 0);
`ifdef REGWB_FWD_EN
            fwd_addr1  = 5'($urandom_range(7));
            fwd_addr2  = 5'($urandom_range(7));
            fwd_rs1_in = $urandom();
            fwd_rs2_in = $urandom();
`endif
        end
    endtask

    task automatic tick(input string tag);
        chk_cycle(tag);
        adv();
    endtask

    initial begin
        int rr_gnt [5];
        int rr_rd  [5];
        int snap;
        rr_gnt = '{1, 2, 4, 1, 2};
        rr_rd  = '{0, 1, 2, 3, 1};
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = '0;
            rf_dut[i]   = '0;
        end
        wr_dut   = 0;
        mode     = 0;
        last_g   = -1;
        nReset   = 1'b0;
        wbStall  = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
`ifdef REGWB_FWD_EN
        fwd_addr1 = '0; fwd_addr2 = '0; fwd_rs1_in = '0; fwd_rs2_in = '0;
`endif
        model_reset();

        // Reset with all requesters pending
        set_req(0, 1'b1, 5'd1, 32'hA);
        set_req(1, 1'b1, 5'd2, 32'hB);
        set_req(2, 1'b1, 5'd3, 32'hC);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("reset.ready", 64'(req_ready), 64'd0);
        chk("reset.wr",    64'(writeRegMem), 64'd0);
        chk("reset.rd",    64'(rd), 64'd0);
        chk("reset.data",  64'(dataIn), 64'd0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;

        // Round robin with all three held valid
        for (int k = 0; k < 5; k++) begin
            chk_cycle("rr");
            chk("rr.grant", 64'(req_ready), 64'(rr_gnt[k]));
            if (k >= 1) begin
                chk("rr.wrseq", 64'(writeRegMem), 64'd1);
                chk("rr.rdseq", 64'(rd), 64'(rr_rd[k]));
            end
            adv();
        end

        // Stall holding rd=5 / 0xDEADBEEF
        mode = 1;
        req_valid = '0;
        tick("drain");
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick("stall.load");
        wbStall = 1'b1;
        set_req(1, 1'b1, 5'd6, 32'h66);
        for (int k = 0; k < 3; k++) begin
            chk_cycle("stall");
            chk("stall.wr0",    64'(writeRegMem), 64'd0);
            chk("stall.ready0", 64'(req_ready), 64'd0);
            adv();
        end
        wbStall = 1'b0;
        chk_cycle("unstall");
        chk("unstall.wr",    64'(writeRegMem), 64'd1);
        chk("unstall.rd",    64'(rd), 64'd5);
        chk("unstall.data",  64'(dataIn), 64'hDEADBEEF);
        chk("unstall.grant", 64'(req_ready), 64'd2);
        adv();
        set_req(2, 1'b1, 5'd10, 32'h77);
        tick("align");

        // x0 request and rd=7 collision starting from rr_ptr=0
        set_req(0, 1'b1, 5'd0, 32'h1);
        set_req(1, 1'b1, 5'd7, 32'h2);
        set_req(2, 1'b1, 5'd7, 32'h3);
        chk_cycle("x0.c1");
        chk("x0.c1.grant", 64'(req_ready), 64'd1);
        adv();
        chk_cycle("x0.c2");
        chk("x0.c2.nowr", 64'(writeRegMem), 64'd0);
        adv();
        chk_cycle("x0.c3");
        chk("x0.c3.data", 64'(dataIn), 64'h2);
        adv();
        chk_cycle("x0.c4");
        chk("x0.c4.data", 64'(dataIn), 64'h3);
        adv();
        chk("x0.final_x7", 64'(rf_dut[7]), 64'h3);

        // Single request then idle: exactly one write pulse, pointer back at 0
        snap = wr_dut;
        set_req(2, 1'b1, 5'd9, 32'h55);
        repeat (4) tick("idle");
        chk("idle.pulses", 64'(wr_dut - snap), 64'd1);
        set_req(0, 1'b1, 5'd11, 32'h11);
        set_req(1, 1'b1, 5'd12, 32'h12);
        set_req(2, 1'b1, 5'd13, 32'h13);
        chk_cycle("idle.ptr");
        chk("idle.ptr.grant", 64'(req_ready), 64'd1);
        adv();

        // Asynchronous reset with an entry staged
        nReset = 1'b0;
        #2;
        chk("areset.wr",    64'(writeRegMem), 64'd0);
        chk("areset.rd",    64'(rd), 64'd0);
        chk("areset.data",  64'(dataIn), 64'd0);
        chk("areset.ready", 64'(req_ready), 64'd0);
        model_reset();
        nReset = 1'b1;
        repeat (3) tick("post_reset");

`ifdef REGWB_FWD_EN
        req_valid = '0;
        tick("fwd.drain");
        set_req(0, 1'b1, 5'd4, 32'h1234);
        tick("fwd.load");
        fwd_addr1  = 5'd4;
        fwd_addr2  = 5'd0;
        fwd_rs1_in = 32'h1111;
        fwd_rs2_in = 32'hCAFE;
        chk_cycle("fwd");
        chk("fwd.rs1", 64'(fwd_rs1), 64'h1234);
        chk("fwd.rs2", 64'(fwd_rs2), 64'hCAFE);
        adv();
`endif

        // Randomized traffic with stalls
        mode = 2;
        for (int k = 0; k < 300; k++) tick("rand");
        wbStall = 1'b0;
        mode = 1;
        req_valid = '0;
        repeat (3) tick("flush");
        for (int i = 0; i < 32; i++) chk($sformatf("rf.x%0d", i), 64'(rf_dut[i]), 64'(rf_model[i]));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (writeRegMem/rd/dataIn) between NUM_REQ writeback sources: ALU, load unit, CSR unit.
- Round-robin arbitration with valid/ready handshake per source, plus a one-entry registered writeback stage that drives the register file.
- Sits between execute/memory units and the register file; supports stall from downstream hazard logic.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width; must match register file width

Ports:
- Clock  input  1  system clock, rising edge
- nReset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  requester i has a write pending
- req_rd  input  NUM_REQ*5  destination register of requester i, bits [5i+4:5i]
- req_data  input  NUM_REQ*XLEN  write data of requester i, bits [XLEN*i+XLEN-1:XLEN*i]
- req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- wbStall  input  1  freeze writeback; no grants, no register-file write
- writeRegMem  output  1  register file write enable
- rd  output  5  register file write address
- dataIn  output  XLEN  register file write data

Behaviour:
- Reset (async, nReset=0): stage_valid=0, rd=0, dataIn=0, writeRegMem=0, req_ready=0, rr_ptr=0. Reset mid-transfer discards the staged entry; the requester must re-present.
- State: stage_valid, stage_rd, stage_data, rr_ptr (clog2(NUM_REQ) bits).
- Outputs: rd=stage_rd, dataIn=stage_data, writeRegMem = stage_valid & ~wbStall & (stage_rd != 0).
- Stage drains in any cycle with stage_valid & ~wbStall. It can accept when ~stage_valid or draining, and ~wbStall.
- Arbitration (combinational): when the stage can accept, search req_valid starting at index rr_ptr, ascending, wrapping at NUM_REQ-1 -> 0. First valid index g gets req_ready[g]=1; all others 0. req_ready depends only on req_valid and state, never on req_rd/req_data.
- At the edge following a transfer: stage_valid=1, stage_rd=req_rd[g], stage_data=req_data[g], rr_ptr = (g+1) mod NUM_REQ. Without a transfer rr_ptr is held.
- Latency: accepted at edge N -> writeRegMem=1 during cycle N..N+1 -> register file updated at edge N+1. Sustained throughput 1 write/cycle.
- Drain without new grant: stage_valid=0 at the next edge.
- wbStall=1: req_ready=0, writeRegMem=0, stage contents held. The held entry is written in the first cycle after wbStall falls. A new grant in that same cycle is permitted, because the stage is draining.
- rd=0 requests: accepted and arbitrated normally and consume a stage slot; writeRegMem stays 0 for that entry.
- Same rd from two requesters in one cycle: only the granted one transfers; the other waits and is written in a later cycle, so the later write wins in the register file.
- Requesters must hold req_valid/req_rd/req_data stable until ready. The arbiter does not check this.
- No requests valid: req_ready=0, stage drains, rr_ptr unchanged.

Optional Feature:
- Macro: REGWB_FWD_EN.
- Defined: adds ports fwd_addr1, fwd_addr2 (input 5), fwd_rs1_in, fwd_rs2_in (input XLEN), fwd_rs1, fwd_rs2 (output XLEN).
- fwd_rsN = dataIn when writeRegMem & (rd == fwd_addrN), else fwd_rsN_in. Purely combinational, so a read in the cycle of the write sees the new value. Address 0 never forwards, because writeRegMem is 0 for rd=0.
- Not defined: ports absent, no forwarding logic.

Test Plan:
- Reset: hold nReset=0 with req_valid=3'b111 -> req_ready=0, writeRegMem=0, rd=0, dataIn=0. Release -> req_ready=3'b001 in the first cycle.
- Round robin: req_valid=3'b111 held, rd=1/2/3, data=0xA/0xB/0xC -> grants 001,010,100,001. writeRegMem=1 every cycle from cycle 2 with rd sequence 1,2,3,1.
- Stall: stage holds rd=5, data=0xDEADBEEF; wbStall=1 for 3 cycles -> writeRegMem=0, req_ready=0 throughout. On the cycle wbStall=0 -> writeRegMem=1, rd=5, dataIn=0xDEADBEEF, and the next request is granted in the same cycle.
- x0 and collision: req0 rd=0 data=0x1, req1 rd=7 data=0x2, req2 rd=7 data=0x3, rr_ptr=0 -> req0 accepted with no write. Then rd=7 written with 0x2, then rd=7 written with 0x3, so the final x7=0x3.
- Idle/drain: single request req2 rd=9 data=0x55 then req_valid=0 -> one write pulse only. stage_valid clears and rr_ptr=0 afterwards.
- REGWB_FWD_EN: writeRegMem=1, rd=4, dataIn=0x1234, fwd_addr1=4, fwd_addr2=0 -> fwd_rs1=0x1234, fwd_rs2=fwd_rs2_in.
